cpu_dma_engine: RTL and testbench
=================================

# cpu_dma_engine

Block-transfer engine on the CPU side of the 16-bit DMA request/ack channel. Given a start address, a word count and a direction, it generates the sequence of DMA requests to the memory side, sourcing write data from an inbound word stream or delivering read data to an outbound word stream. It sits between CPU-controlled peripherals (USB/SD FIFOs) and the memory arbiter, replacing per-word CPU loops.

## Interface
Parameters:
- none

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; begins transfer with current start_address/length/direction; ignored while busy
- stop  in  1  one-cycle pulse; aborts transfer at next word boundary
- direction  in  1  0 = memory→stream (read), 1 = stream→memory (write)
- start_address  in  32  byte address of first word; bit 0 ignored
- length  in  24  transfer length in 16-bit words
- busy  out  1  transfer in progress
- done  out  1  one-cycle pulse at completion or abort
- rx_valid / rx_data[15:0] / rx_ready  in/in/out  write-mode source stream
- tx_valid / tx_data[15:0] / tx_ready  out/out/in  read-mode sink stream
- dma_request, dma_write, dma_address[31:0], dma_wdata[15:0]  out  DMA channel to memory
- dma_ack, dma_rdata[15:0]  in  DMA channel from memory

## Operation
- States: IDLE, FETCH, REQUEST, DELIVER.
- IDLE: busy=0. start with length≠0 latches address (bit0 forced 0), remaining=length, direction; → FETCH (write) or REQUEST (read). start with length=0: stay IDLE, done pulses next cycle.
- FETCH: rx_ready=1. rx_valid&rx_ready latches rx_data into dma_wdata → REQUEST.
- REQUEST: dma_request=1, dma_write=direction; address/write/wdata held stable until ack. On dma_ack: address+=2 (32-bit wrap, 0xFFFFFFFE→0), remaining−=1; read mode latches dma_rdata into tx_data → DELIVER; write mode → FETCH if remaining>0 else IDLE+done.
- DELIVER: tx_valid=1, tx_data stable until tx_ready. On handshake → REQUEST if remaining>0 else IDLE+done.
- stop: latched as abort flag. Raised request is never withdrawn; abort takes effect after the in-flight ack (write) or after the pending tx handshake (read). In FETCH or with no request outstanding, abort → IDLE+done next cycle. Aborted write does not consume another rx word.
- start and stop in same IDLE cycle: start ignored, no done.
- dma_ack outside REQUEST ignored.
- Reset (any time, including mid-transfer): IDLE; busy=0, done=0, rx_ready=0, tx_valid=0, dma_request=0, dma_write=0, dma_address=0, dma_wdata=0, tx_data=0; abort flag and counters cleared.

## Timing
- All outputs registered.
- start at edge N → busy=1 after N; read: dma_request=1 after N; write: rx_ready=1 after N.
- rx handshake at edge M → dma_request=1 after M.
- dma_ack sampled at edge K → dma_request=0 after K (one-cycle request gap between words minimum).
- Read: tx_valid=1 after ack edge K; next dma_request after tx handshake edge.
- done high for exactly one cycle, concurrent with busy falling.
- Peak throughput: one word per 2 cycles with zero-wait ack and always-ready stream.

## Configuration
- CPU_DMA_ENGINE_SWAP_EN defined: bytes swapped on both paths (dma_wdata = {rx_data[7:0], rx_data[15:8]}, tx_data = {dma_rdata[7:0], dma_rdata[15:8]}).
- Undefined: data passed unmodified.

## Test plan
- Read, start_address=0x00001000, length=3, ack after 2 wait cycles, tx_ready=1 → requests at 0x1000/0x1002/0x1004 with dma_write=0, three tx words equal to rdata, one done pulse, busy low.
- Write, start_address=0x00000101, length=2, rx words 0xA55A, 0x1234 → addresses 0x0100, 0x0102, dma_wdata matches (swapped 0x5AA5/0x3412 with SWAP_EN).
- start_address=0xFFFFFFFE, length=2 read → second request at 0x00000000.
- length=0 start → no dma_request, done pulse one cycle after start, busy stays 0.
- stop during REQUEST with ack delayed 5 cycles → request held until ack, then done, no further requests; remaining words unused.
- reset asserted mid-REQUEST → all outputs 0 immediately; later start runs a clean transfer.

Source files
------------

// File: rtl/cpu_dma_engine.sv
// -----------------------------------------------------------------------------
// cpu_dma_engine
//
// Block-transfer engine on the CPU side of the 16-bit DMA request/ack channel.
// Given a start address, a word count and a direction, it issues one DMA
// request per 16-bit word. In write mode each word comes from the inbound rx
// stream. In read mode each word goes out on the outbound tx stream. This
// replaces per-word CPU copy loops between peripheral FIFOs and the memory
// arbiter.
//
// Ports
//   clk, reset             system clock, asynchronous active-high reset
//   start, stop            one-cycle control pulses (start ignored while busy)
//   direction              0 = memory -> tx stream, 1 = rx stream -> memory
//   start_address[31:0]    byte address of the first word (bit 0 ignored)
//   length[23:0]           transfer length in 16-bit words
//   busy, done             transfer in progress / one-cycle completion pulse
//   rx_valid, rx_data,     write-mode source stream
//   rx_ready
//   tx_valid, tx_data,     read-mode sink stream
//   tx_ready
//   dma_request, dma_write,
//   dma_address, dma_wdata request channel to memory
//   dma_ack, dma_rdata     response channel from memory
//
// Configuration
//   CPU_DMA_ENGINE_SWAP_EN  when defined, the two bytes of every word are
//                           swapped on both the rx->memory and memory->tx
//                           paths. When undefined, data passes unmodified.
//
// Every output is driven directly by a register.
// -----------------------------------------------------------------------------
module cpu_dma_engine (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  input  logic        direction,
  input  logic [31:0] start_address,
  input  logic [23:0] length,
  output logic        busy,
  output logic        done,
  input  logic        rx_valid,
  input  logic [15:0] rx_data,
  output logic        rx_ready,
  output logic        tx_valid,
  output logic [15:0] tx_data,
  input  logic        tx_ready,
  output logic        dma_request,
  output logic        dma_write,
  output logic [31:0] dma_address,
  output logic [15:0] dma_wdata,
  input  logic        dma_ack,
  input  logic [15:0] dma_rdata
);

  // ---------------------------------------------------------------------------
  // State encoding
  // ---------------------------------------------------------------------------
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_FETCH   = 2'd1;  // waiting for an rx word
  localparam logic [1:0] ST_REQUEST = 2'd2;  // request raised, waiting for ack
  localparam logic [1:0] ST_DELIVER = 2'd3;  // read word waiting on tx handshake

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  logic [1:0]  state_q,       state_d;
  logic        dir_q,         dir_d;
  logic        abort_q,       abort_d;
  logic [23:0] remaining_q,   remaining_d;
  logic        busy_q,        busy_d;
  logic        done_q,        done_d;
  logic        rx_ready_q,    rx_ready_d;
  logic        tx_valid_q,    tx_valid_d;
  logic [15:0] tx_data_q,     tx_data_d;
  logic        dma_request_q, dma_request_d;
  logic        dma_write_q,   dma_write_d;
  logic [31:0] dma_address_q, dma_address_d;
  logic [15:0] dma_wdata_q,   dma_wdata_d;

  // ---------------------------------------------------------------------------
  // Optional byte swap on both data paths
  // ---------------------------------------------------------------------------
  logic [15:0] rx_word;
  logic [15:0] rd_word;

`ifdef CPU_DMA_ENGINE_SWAP_EN
  assign rx_word = {rx_data[7:0],   rx_data[15:8]};
  assign rd_word = {dma_rdata[7:0], dma_rdata[15:8]};
`else
  assign rx_word = rx_data;
  assign rd_word = dma_rdata;
`endif

  // A stop pulse in the current cycle counts the same as one latched earlier,
  // so an abort never has to wait an extra cycle to be noticed.
  logic abort_now;
  assign abort_now = abort_q | stop;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every _d starts as its _q (done starts at 0). This way each path
    // through the case assigns every signal, and no latch is inferred.
    state_d       = state_q;
    dir_d         = dir_q;
    abort_d       = abort_q;
    remaining_d   = remaining_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    rx_ready_d    = rx_ready_q;
    tx_valid_d    = tx_valid_q;
    tx_data_d     = tx_data_q;
    dma_request_d = dma_request_q;
    dma_write_d   = dma_write_q;
    dma_address_d = dma_address_q;
    dma_wdata_d   = dma_wdata_q;

    case (state_q)
      ST_IDLE: begin
        abort_d = 1'b0;
        // When start and stop arrive together, stop wins. Nothing starts and
        // done does not pulse.
        if (start && !stop) begin
          if (length == 24'd0) begin
            done_d = 1'b1;
          end else begin
            dma_address_d = start_address & 32'hFFFF_FFFE;
            remaining_d   = length;
            dir_d         = direction;
            busy_d        = 1'b1;
            if (direction) begin
              state_d    = ST_FETCH;
              rx_ready_d = 1'b1;
            end else begin
              state_d       = ST_REQUEST;
              dma_request_d = 1'b1;
              dma_write_d   = 1'b0;
            end
          end
        end
      end

      ST_FETCH: begin
        // No request is outstanding here, so an abort ends the transfer at
        // once. An rx word offered in the same cycle is not taken.
        if (abort_now) begin
          state_d       = ST_IDLE;
          busy_d        = 1'b0;
          done_d        = 1'b1;
          rx_ready_d    = 1'b0;
          tx_valid_d    = 1'b0;
          dma_request_d = 1'b0;
          dma_write_d   = 1'b0;
          abort_d       = 1'b0;
        end else if (rx_valid && rx_ready_q) begin
          dma_wdata_d   = rx_word;
          rx_ready_d    = 1'b0;
          state_d       = ST_REQUEST;
          dma_request_d = 1'b1;
          dma_write_d   = 1'b1;
        end
      end

      ST_REQUEST: begin
        // A raised request is never withdrawn. The stop is only recorded here,
        // and it takes effect once the ack arrives.
        if (stop) abort_d = 1'b1;
        if (dma_ack) begin
          dma_request_d = 1'b0;
          dma_write_d   = 1'b0;
          dma_address_d = dma_address_q + 32'd2;  // wraps 0xFFFFFFFE -> 0
          remaining_d   = remaining_q - 24'd1;
          if (!dir_q) begin
            // In read mode the word still has to be delivered, even when an
            // abort is pending.
            tx_data_d  = rd_word;
            tx_valid_d = 1'b1;
            state_d    = ST_DELIVER;
          end else if ((remaining_q == 24'd1) || abort_now) begin
            state_d    = ST_IDLE;
            busy_d     = 1'b0;
            done_d     = 1'b1;
            rx_ready_d = 1'b0;
            abort_d    = 1'b0;
          end else begin
            state_d    = ST_FETCH;
            rx_ready_d = 1'b1;
          end
        end
      end

      ST_DELIVER: begin
        if (stop) abort_d = 1'b1;
        if (tx_ready) begin
          tx_valid_d = 1'b0;
          if ((remaining_q == 24'd0) || abort_now) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            abort_d = 1'b0;
          end else begin
            state_d       = ST_REQUEST;
            dma_request_d = 1'b1;
            dma_write_d   = 1'b0;
          end
        end
      end

      default: begin
        state_d       = ST_IDLE;
        busy_d        = 1'b0;
        rx_ready_d    = 1'b0;
        tx_valid_d    = 1'b0;
        dma_request_d = 1'b0;
        dma_write_d   = 1'b0;
        abort_d       = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: non-blocking assignments. Every flop samples its _d value from
  // before this clock edge, whatever order the statements are written in.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      dir_q         <= 1'b0;
      abort_q       <= 1'b0;
      remaining_q   <= 24'd0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      rx_ready_q    <= 1'b0;
      tx_valid_q    <= 1'b0;
      tx_data_q     <= 16'd0;
      dma_request_q <= 1'b0;
      dma_write_q   <= 1'b0;
      dma_address_q <= 32'd0;
      dma_wdata_q   <= 16'd0;
    end else begin
      state_q       <= state_d;
      dir_q         <= dir_d;
      abort_q       <= abort_d;
      remaining_q   <= remaining_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      rx_ready_q    <= rx_ready_d;
      tx_valid_q    <= tx_valid_d;
      tx_data_q     <= tx_data_d;
      dma_request_q <= dma_request_d;
      dma_write_q   <= dma_write_d;
      dma_address_q <= dma_address_d;
      dma_wdata_q   <= dma_wdata_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign busy        = busy_q;
  assign done        = done_q;
  assign rx_ready    = rx_ready_q;
  assign tx_valid    = tx_valid_q;
  assign tx_data     = tx_data_q;
  assign dma_request = dma_request_q;
  assign dma_write   = dma_write_q;
  assign dma_address = dma_address_q;
  assign dma_wdata   = dma_wdata_q;

endmodule

// File: tb/tb_cpu_dma_engine.sv
// -----------------------------------------------------------------------------
// tb_cpu_dma_engine
//
// Scoreboard bench for cpu_dma_engine. The stimulus process pushes the
// expected DMA requests, tx words and done pulses into queues. A monitor
// process pops them and compares them whenever the DUT presents a new request,
// a tx handshake or a done pulse. A memory responder acks after a programmable
// wait and returns rdata = address[15:0] ^ 16'hC3C3. An rx source feeds words
// from a queue.
// -----------------------------------------------------------------------------
module tb_cpu_dma_engine;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        direction = 1'b0;
  logic [31:0] start_address = 32'd0;
  logic [23:0] length = 24'd0;
  logic        busy, done;
  logic        rx_valid = 1'b0;
  logic [15:0] rx_data = 16'd0;
  logic        rx_ready;
  logic        tx_valid;
  logic [15:0] tx_data;
  logic        tx_ready = 1'b1;
  logic        dma_request, dma_write;
  logic [31:0] dma_address;
  logic [15:0] dma_wdata;
  logic        dma_ack = 1'b0;
  logic [15:0] dma_rdata = 16'd0;

  cpu_dma_engine dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .stop          (stop),
    .direction     (direction),
    .start_address (start_address),
    .length        (length),
    .busy          (busy),
    .done          (done),
    .rx_valid      (rx_valid),
    .rx_data       (rx_data),
    .rx_ready      (rx_ready),
    .tx_valid      (tx_valid),
    .tx_data       (tx_data),
    .tx_ready      (tx_ready),
    .dma_request   (dma_request),
    .dma_write     (dma_write),
    .dma_address   (dma_address),
    .dma_wdata     (dma_wdata),
    .dma_ack       (dma_ack),
    .dma_rdata     (dma_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        write;
    logic [15:0] wdata;
  } req_t;

  req_t        req_q[$];
  logic [15:0] tx_q[$];
  logic [15:0] rx_words[$];
  int          exp_done = 0;
  int          ack_wait = 0;
  int          n_pass = 0;
  int          n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  function automatic logic [15:0] sw(input logic [15:0] w);
`ifdef CPU_DMA_ENGINE_SWAP_EN
    return {w[7:0], w[15:8]};
`else
    return w;
`endif
  endfunction

  function automatic req_t mk_req(input logic [31:0] a, input logic w, input logic [15:0] d);
    req_t r;
    r.addr = a; r.write = w; r.wdata = d;
    return r;
  endfunction

  // Memory responder: acks after ack_wait cycles of a raised request.
  initial begin
    int wait_cnt = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        dma_ack = 1'b0;
        wait_cnt = 0;
      end else if (dma_ack) begin
        dma_ack = 1'b0;
      end else if (dma_request) begin
        if (wait_cnt >= ack_wait) begin
          dma_ack   = 1'b1;
          dma_rdata = dma_address[15:0] ^ 16'hC3C3;
          wait_cnt  = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // rx source: presents the front of rx_words and pops it once it has been taken.
  initial begin
    logic rx_fire = 1'b0;
    forever begin
      @(negedge clk);
      if (rx_fire && rx_words.size() > 0) void'(rx_words.pop_front());
      if (rx_words.size() > 0) begin
        rx_valid = 1'b1;
        rx_data  = rx_words[0];
      end else begin
        rx_valid = 1'b0;
      end
      rx_fire = rx_valid && rx_ready && !reset;
    end
  end

  // Monitor: compares the DUT outputs against the scoreboard queues.
  initial begin
    logic prev_req = 1'b0;
    req_t cur;
    cur = mk_req(32'd0, 1'b0, 16'd0);
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_req = 1'b0;
      end else begin
        if (dma_request && !prev_req) begin
          check("req_expected", 32'(req_q.size() > 0), 32'd1);
          if (req_q.size() > 0) begin
            cur = req_q.pop_front();
            check("req_addr", dma_address, cur.addr);
            check("req_write", 32'(dma_write), 32'(cur.write));
            if (cur.write) check("req_wdata", 32'(dma_wdata), 32'(cur.wdata));
          end
        end else if (dma_request && prev_req) begin
          check("req_addr_stable", dma_address, cur.addr);
        end
        if (tx_valid && tx_ready) begin
          check("tx_expected", 32'(tx_q.size() > 0), 32'd1);
          if (tx_q.size() > 0) check("tx_data", 32'(tx_data), 32'(tx_q.pop_front()));
        end
        if (done) begin
          check("done_expected", 32'(exp_done > 0), 32'd1);
          if (exp_done > 0) exp_done--;
          check("busy_low_with_done", 32'(busy), 32'd0);
        end
        prev_req = dma_request;
      end
    end
  end

  task automatic pulse_start(input logic dir, input logic [31:0] addr, input logic [23:0] len);
    @(negedge clk);
    direction     = dir;
    start_address = addr;
    length        = len;
    start         = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset state.
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_req", 32'(dma_request), 32'd0);
    check("rst_rx_ready", 32'(rx_ready), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Read of 3 words at 0x1000, with the ack 2 cycles late.
    ack_wait = 2;
    req_q.push_back(mk_req(32'h0000_1000, 1'b0, 16'h0));
    req_q.push_back(mk_req(32'h0000_1002, 1'b0, 16'h0));
    req_q.push_back(mk_req(32'h0000_1004, 1'b0, 16'h0));
    tx_q.push_back(sw(16'hD3C3));
    tx_q.push_back(sw(16'hD3C1));
    tx_q.push_back(sw(16'hD3C7));
    exp_done++;
    pulse_start(1'b0, 32'h0000_1000, 24'd3);
    check("rd_busy_after_start", 32'(busy), 32'd1);
    check("rd_req_after_start", 32'(dma_request), 32'd1);
    wait_idle("rd_idle", 200);
    check("rd_tx_valid_low", 32'(tx_valid), 32'd0);

    // Address wraps from 0xFFFFFFFE to 0 (zero-wait ack).
    ack_wait = 0;
    req_q.push_back(mk_req(32'hFFFF_FFFE, 1'b0, 16'h0));
    req_q.push_back(mk_req(32'h0000_0000, 1'b0, 16'h0));
    tx_q.push_back(sw(16'h3C3D));
    tx_q.push_back(sw(16'hC3C3));
    exp_done++;
    pulse_start(1'b0, 32'hFFFF_FFFE, 24'd2);
    wait_idle("wrap_idle", 200);

    // A zero-length start pulses done one cycle later and never goes busy.
    exp_done++;
    pulse_start(1'b0, 32'h0000_4000, 24'd0);
    check("len0_done", 32'(done), 32'd1);
    check("len0_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("len0_done_one_cycle", 32'(done), 32'd0);
    check("len0_no_req", 32'(dma_request), 32'd0);

    // start and stop in the same idle cycle: start is ignored.
    @(negedge clk);
    direction = 1'b0; start_address = 32'h0000_5000; length = 24'd5;
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    check("startstop_busy", 32'(busy), 32'd0);
    check("startstop_req", 32'(dma_request), 32'd0);
    @(negedge clk);
    check("startstop_no_done", 32'(done), 32'd0);

    // Reset asserted while a request is outstanding.
    ack_wait = 100;
    req_q.push_back(mk_req(32'h0000_2000, 1'b0, 16'h0));
    pulse_start(1'b0, 32'h0000_2000, 24'd4);
    repeat (3) @(negedge clk);
    check("rst_mid_req_held", 32'(dma_request), 32'd1);
    reset = 1'b1;
    #1;
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_done", 32'(done), 32'd0);
    check("rst_mid_rx_ready", 32'(rx_ready), 32'd0);
    check("rst_mid_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_mid_req", 32'(dma_request), 32'd0);
    check("rst_mid_write", 32'(dma_write), 32'd0);
    check("rst_mid_addr", dma_address, 32'd0);
    check("rst_mid_wdata", 32'(dma_wdata), 32'd0);
    check("rst_mid_tx_data", 32'(tx_data), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    ack_wait = 0;

    // Write of 2 words from odd address 0x101; bit 0 is dropped.
    rx_words.push_back(16'hA55A);
    rx_words.push_back(16'h1234);
    req_q.push_back(mk_req(32'h0000_0100, 1'b1, sw(16'hA55A)));
    req_q.push_back(mk_req(32'h0000_0102, 1'b1, sw(16'h1234)));
    exp_done++;
    pulse_start(1'b1, 32'h0000_0101, 24'd2);
    check("wr_busy_after_start", 32'(busy), 32'd1);
    check("wr_rx_ready_after_start", 32'(rx_ready), 32'd1);
    check("wr_no_req_yet", 32'(dma_request), 32'd0);
    wait_idle("wr_idle", 200);
    check("wr_rx_consumed", 32'(rx_words.size()), 32'd0);

    // Stop while a write request waits 5 cycles for its ack.
    ack_wait = 5;
    rx_words.push_back(16'hBEEF);
    rx_words.push_back(16'h5555);
    req_q.push_back(mk_req(32'h0000_3000, 1'b1, sw(16'hBEEF)));
    exp_done++;
    pulse_start(1'b1, 32'h0000_3000, 24'd4);
    begin
      int n = 0;
      while (!dma_request && n < 20) begin
        @(negedge clk);
        n++;
      end
    end
    check("stop_req_seen", 32'(dma_request), 32'd1);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check("stop_req_held", 32'(dma_request), 32'd1);
    wait_idle("stop_idle", 100);
    check("stop_rx_not_taken", 32'(rx_words.size()), 32'd1);
    repeat (10) @(negedge clk);
    check("stop_rx_ready_low", 32'(rx_ready), 32'd0);
    check("stop_no_more_req", 32'(dma_request), 32'd0);
    rx_words.delete();
    ack_wait = 0;

    repeat (5) @(negedge clk);
    check("req_queue_drained", 32'(req_q.size()), 32'd0);
    check("tx_queue_drained", 32'(tx_q.size()), 32'd0);
    check("done_all_seen", 32'(exp_done), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
